// File: rtl/freq_meas_scheduler.sv
// rtl/freq_meas_scheduler.sv - ring-oscillator frequency measurement sequencer
// Walks the enabled sensors in ascending order: select, settle (clear), gate, drain, capture.
module freq_meas_scheduler #(
    parameter  int NUM_SENSORS  = 4,
    parameter  int CNT_WIDTH    = 32,
    parameter  int GATE_WIDTH   = 32,
    parameter  int DRAIN_CYCLES = 4,
    localparam int SEL_WIDTH    = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_enable,
    input  logic                   cfg_continuous,
    input  logic [NUM_SENSORS-1:0] cfg_sensor_mask,
    input  logic [GATE_WIDTH-1:0]  cfg_gate_cycles,
    input  logic [7:0]             cfg_settle_cycles,
    input  logic                   start,
    output logic [SEL_WIDTH-1:0]   sensor_sel,
    output logic                   cnt_clear,
    output logic                   cnt_enable,
    input  logic [CNT_WIDTH-1:0]   cnt_value,
    input  logic                   cnt_ovf,
    output logic                   res_valid,
    output logic [SEL_WIDTH-1:0]   res_index,
    output logic [CNT_WIDTH-1:0]   res_data,
    output logic                   res_ovf,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam int PTR_W = $clog2(NUM_SENSORS + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        GATE    = 3'd3,
        DRAIN   = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [7:0]             settle_q, settle_d;
    logic [GATE_WIDTH-1:0]  gate_q, gate_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   latch_cfg;

    // Shadow copies so register-bank writes mid-sweep cannot disturb it
    logic [NUM_SENSORS-1:0] mask_sh_q;
    logic [GATE_WIDTH-1:0]  gate_sh_q;
    logic [7:0]             settle_sh_q;

    logic                   found;
    logic [SEL_WIDTH-1:0]   found_idx;

    logic                   cnt_clear_q, cnt_enable_q, busy_q, sweep_done_q;
    logic                   res_valid_q, res_ovf_q;
    logic [SEL_WIDTH-1:0]   res_index_q;
    logic [CNT_WIDTH-1:0]   res_data_q;

    // Descending scan so the lowest qualifying index wins
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (mask_sh_q[i] && (PTR_W'(i) >= ptr_q)) begin
                found     = 1'b1;
                found_idx = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        settle_d  = settle_q;
        gate_d    = gate_q;
        drain_d   = drain_q;
        latch_cfg = 1'b0;
        if (state_q != IDLE && !cfg_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && cfg_enable) begin
                        latch_cfg = 1'b1;
                        ptr_d     = '0;
                        state_d   = SELECT;
                    end
                end
                SELECT: begin
                    if (found) begin
                        sel_d    = found_idx;
                        ptr_d    = PTR_W'(found_idx) + PTR_W'(1);
                        settle_d = settle_sh_q;
                        state_d  = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                SETTLE: begin
                    if (settle_q == 8'd0) begin
                        gate_d  = (gate_sh_q == '0) ? GATE_WIDTH'(1) : gate_sh_q;
                        state_d = GATE;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
                GATE: begin
                    // Compare against <=1 so a zero count can never wrap
                    if (gate_q <= GATE_WIDTH'(1)) begin
                        drain_d = DRN_W'(DRAIN_CYCLES - 1);
                        state_d = DRAIN;
                    end else begin
                        gate_d = gate_q - GATE_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        drain_d = drain_q - DRN_W'(1);
                    end
                end
                CAPTURE: begin
                    state_d = SELECT;
                end
                DONE: begin
                    if (cfg_continuous) begin
                        latch_cfg = 1'b1;
                        ptr_d     = '0;
                        state_d   = SELECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            settle_q    <= '0;
            gate_q      <= '0;
            drain_q     <= '0;
            mask_sh_q   <= '0;
            gate_sh_q   <= '0;
            settle_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            settle_q <= settle_d;
            gate_q   <= gate_d;
            drain_q  <= drain_d;
            if (latch_cfg) begin
                mask_sh_q   <= cfg_sensor_mask;
                gate_sh_q   <= cfg_gate_cycles;
                settle_sh_q <= cfg_settle_cycles;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_clear_q  <= 1'b0;
            cnt_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_index_q  <= '0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            cnt_clear_q  <= (state_d == SETTLE);
            cnt_enable_q <= (state_d == GATE);
            busy_q       <= (state_d != IDLE);
            sweep_done_q <= (state_d == DONE);
            res_valid_q  <= (state_d == CAPTURE);
            if (state_d == CAPTURE) begin
                res_index_q <= sel_q;
                res_data_q  <= cnt_ovf ? {CNT_WIDTH{1'b1}} : cnt_value;
                res_ovf_q   <= cnt_ovf;
            end
        end
    end

    assign sensor_sel = sel_q;
    assign cnt_clear  = cnt_clear_q;
    assign cnt_enable = cnt_enable_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign res_valid  = res_valid_q;
    assign res_index  = res_index_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;

    a_no_clear_and_gate: assert property (@(posedge ACLK) disable iff (!ARESETN)
        !(cnt_clear && cnt_enable));

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// tb/tb_freq_meas_scheduler.sv - scoreboard bench for freq_meas_scheduler
module tb_freq_meas_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_enable = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic [3:0]  cfg_sensor_mask = '0;
    logic [31:0] cfg_gate_cycles = '0;
    logic [7:0]  cfg_settle_cycles = '0;
    logic        start = 1'b0;
    logic [1:0]  sensor_sel;
    logic        cnt_clear, cnt_enable;
    logic [31:0] cnt_value;
    logic        cnt_ovf = 1'b0;
    logic        res_valid;
    logic [1:0]  res_index;
    logic [31:0] res_data;
    logic        res_ovf, busy, sweep_done;

    freq_meas_scheduler dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
        .cfg_sensor_mask(cfg_sensor_mask), .cfg_gate_cycles(cfg_gate_cycles),
        .cfg_settle_cycles(cfg_settle_cycles), .start(start),
        .sensor_sel(sensor_sel), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
        .cnt_value(cnt_value), .cnt_ovf(cnt_ovf),
        .res_valid(res_valid), .res_index(res_index), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy), .sweep_done(sweep_done)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Oscillator model: sensor k adds k+1 per gated cycle, seen through a 2-flop sync
    logic [31:0] osc = '0, s1 = '0, s2 = '0;
    always @(posedge ACLK) begin
        if (cnt_clear) osc <= '0;
        else if (cnt_enable) osc <= osc + 32'(sensor_sel) + 32'd1;
        s1 <= osc;
        s2 <= s1;
    end
    assign cnt_value = s2;

    typedef struct {
        bit          is_done;
        int          idx;
        logic [31:0] data;
        bit          ovf;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int fails = 0;
    int en_cnt = 0;
    int clr_cnt = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_res(int idx, logic [31:0] data, bit ovf, int c);
        exp_t e;
        e.is_done = 1'b0; e.idx = idx; e.data = data; e.ovf = ovf; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done(int c);
        exp_t e;
        e.is_done = 1'b1; e.idx = 0; e.data = '0; e.ovf = 1'b0; e.cyc = c;
        exp_q.push_back(e);
    endtask

    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (cnt_enable) en_cnt++;
            if (cnt_clear) clr_cnt++;
            if (cnt_enable && cnt_clear) chk("clear_gate_overlap", 1, 0);
            if (res_valid || sweep_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {62'd0, res_valid, sweep_done}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("output_kind", sweep_done, e.is_done);
                    chk("output_cycle", cyc, e.cyc);
                    if (!e.is_done) begin
                        chk("res_index", res_index, e.idx);
                        chk("res_data", res_data, e.data);
                        chk("res_ovf", res_ovf, e.ovf);
                    end
                end
            end
        end
    end

    task automatic do_start(output int t0);
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge ACLK);
    endtask

    task automatic wait_drain(int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge ACLK);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_sensor_sel"}, sensor_sel, 0);
        chk({tag, "_cnt_clear"}, cnt_clear, 0);
        chk({tag, "_cnt_enable"}, cnt_enable, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_index"}, res_index, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_ovf"}, res_ovf, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sweep_done"}, sweep_done, 0);
    endtask

    task automatic reset_pulse(string tag);
        #1 ARESETN = 1'b0;
        #1 check_reset_outputs(tag);
        exp_q.delete();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic set_cfg(logic [3:0] m, logic [7:0] s, logic [31:0] g);
        cfg_sensor_mask = m; cfg_settle_cycles = s; cfg_gate_cycles = g;
        en_cnt = 0; clr_cnt = 0;
    endtask

    task automatic sweep_0101(string tag);
        int t0;
        set_cfg(4'b0101, 8'd2, 32'd100);
        do_start(t0);
        chk({tag, "_busy_rise"}, busy, 1);
        push_res(0, 32'd100, 1'b0, t0 + 108);
        push_res(2, 32'd300, 1'b0, t0 + 217);
        push_done(t0 + 219);
        wait_drain(400);
        chk({tag, "_gate_cycles"}, en_cnt, 200);
        chk({tag, "_clear_cycles"}, clr_cnt, 6);
        @(negedge ACLK);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_sel_hold"}, sensor_sel, 2);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge ACLK);
        check_reset_outputs("por");
        ARESETN = 1'b1;
        cfg_enable = 1'b1;
        repeat (2) @(negedge ACLK);

        sweep_0101("two_sensor");

        set_cfg(4'b0000, 8'd2, 32'd100);
        do_start(t0);
        push_done(t0 + 1);
        wait_drain(20);
        chk("empty_gate_cycles", en_cnt, 0);
        chk("empty_clear_cycles", clr_cnt, 0);

        set_cfg(4'b0001, 8'd0, 32'd0);
        do_start(t0);
        push_res(0, 32'd1, 1'b0, t0 + 7);
        push_done(t0 + 9);
        wait_drain(40);
        chk("g0_gate_cycles", en_cnt, 1);
        chk("g0_clear_cycles", clr_cnt, 1);

        cfg_continuous = 1'b1;
        set_cfg(4'b1111, 8'd1, 32'd20);
        do_start(t0);
        push_res(0, 32'd20, 1'b0, t0 + 27);
        push_res(1, 32'd40, 1'b0, t0 + 55);
        wait_cyc(t0 + 65);
        chk("abort_sel", sensor_sel, 2);
        chk("abort_gate_before", cnt_enable, 1);
        cfg_enable = 1'b0;
        @(negedge ACLK);
        chk("abort_gate_after", cnt_enable, 0);
        chk("abort_clear_after", cnt_clear, 0);
        chk("abort_busy_after", busy, 0);
        repeat (40) @(negedge ACLK);
        chk("abort_pending", exp_q.size(), 0);
        cfg_enable = 1'b1;
        cfg_continuous = 1'b0;
        repeat (3) @(negedge ACLK);

        cnt_ovf = 1'b1;
        set_cfg(4'b0010, 8'd0, 32'd5);
        do_start(t0);
        push_res(1, 32'hFFFF_FFFF, 1'b1, t0 + 11);
        push_done(t0 + 13);
        start = 1'b1; @(negedge ACLK); start = 1'b0;
        wait_cyc(t0 + 5);
        start = 1'b1; @(negedge ACLK); start = 1'b0;
        wait_drain(50);
        repeat (20) @(negedge ACLK);
        chk("ovf_busy_idle", busy, 0);
        cnt_ovf = 1'b0;

        set_cfg(4'b0101, 8'd2, 32'd100);
        do_start(t0);
        push_res(0, 32'd100, 1'b0, t0 + 108);
        wait_cyc(t0 + 50);
        chk("rst_gate_enable_before", cnt_enable, 1);
        reset_pulse("rst_gate");
        repeat (2) @(negedge ACLK);
        do_start(t0);
        push_res(0, 32'd100, 1'b0, t0 + 108);
        wait_cyc(t0 + 105);
        chk("rst_drain_busy_before", busy, 1);
        chk("rst_drain_enable_before", cnt_enable, 0);
        reset_pulse("rst_drain");
        repeat (2) @(negedge ACLK);
        sweep_0101("post_reset");

        repeat (5) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
